// File: rtl/tm_dram_timer_if.sv
// Request-token bundle from the CPU/L1 memory-request stage into tm_dram_timer.
// The master drives one token per host cycle; the timer consumes it as slave.
interface tm_dram_timer_if #(
  parameter int unsigned TIDW = 6
);
  logic            req_token_valid;
  logic [TIDW-1:0] req_tid;
  logic            req_valid;
  logic            req_wb;

  modport master (output req_token_valid, req_tid, req_valid, req_wb);
  modport slave  (input  req_token_valid, req_tid, req_valid, req_wb);
endinterface

// File: rtl/tm_dram_timer.sv
// Target-time single-channel DRAM model: per-thread remaining-miss-latency counters plus
// channel occupancy. Optional statistics counters are enabled with TM_DRAM_STATS_EN.
module tm_dram_timer #(
  parameter int unsigned NT   = 64,
  parameter int unsigned TIDW = 6,
  parameter int unsigned LATW = 10
) (
  input  logic                gclk,
  input  logic                rst,
  input  logic                tick,
  tm_dram_timer_if.slave      req,
  input  logic [LATW-1:0]     access_time,
  input  logic [LATW-1:0]     cycle_time,
  output logic [NT-1:0]       stay_stalled,
  output logic                busy_drop,
  output logic [LATW-1:0]     chan_busy
`ifdef TM_DRAM_STATS_EN
  ,
  output logic [31:0]         stat_reqs,
  output logic [31:0]         stat_wbs,
  output logic [31:0]         stat_stall_cycles
`endif
);

  localparam int unsigned SW = LATW + 2;
  localparam logic [SW-1:0] SAT_MAX = {2'b00, {LATW{1'b1}}};

  logic [NT-1:0][LATW-1:0] rem_q, rem_d;
  logic [LATW-1:0]         occ_q, occ_d, occ_t;
  logic [NT-1:0]           stay_stalled_q, stay_stalled_d;
  logic                    busy_drop_q, busy_drop_d;
  logic                    req_hit, tid_idle, accept;
  logic [SW-1:0]           wb_cyc, rem_sum, occ_sum;

  always_comb begin
    occ_t = (tick && occ_q != '0) ? occ_q - LATW'(1) : occ_q;
    for (int unsigned t = 0; t < NT; t++) begin
      rem_d[t] = (tick && rem_q[t] != '0) ? rem_q[t] - LATW'(1) : rem_q[t];
    end

    // Acceptance looks at the pre-tick counter: a thread still waiting this cycle drops.
    req_hit     = req.req_token_valid & req.req_valid;
    tid_idle    = (rem_q[req.req_tid] == '0);
    accept      = req_hit & tid_idle;
    busy_drop_d = req_hit & ~tid_idle;

    // A writeback adds one extra cycle_time to both latency and occupancy.
    wb_cyc  = req.req_wb ? {2'b00, cycle_time} : '0;
    rem_sum = {2'b00, occ_t} + {2'b00, access_time} + wb_cyc;
    occ_sum = {2'b00, occ_t} + {2'b00, cycle_time} + wb_cyc;

    occ_d = occ_t;
    if (accept) begin
      rem_d[req.req_tid] = (rem_sum > SAT_MAX) ? '1 : rem_sum[LATW-1:0];
      occ_d              = (occ_sum > SAT_MAX) ? '1 : occ_sum[LATW-1:0];
    end

    for (int unsigned t = 0; t < NT; t++) begin
      stay_stalled_d[t] = (rem_d[t] != '0);
    end
  end

  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      rem_q          <= '0;
      occ_q          <= '0;
      stay_stalled_q <= '0;
      busy_drop_q    <= 1'b0;
    end else begin
      rem_q          <= rem_d;
      occ_q          <= occ_d;
      stay_stalled_q <= stay_stalled_d;
      busy_drop_q    <= busy_drop_d;
    end
  end

  assign stay_stalled = stay_stalled_q;
  assign busy_drop    = busy_drop_q;
  assign chan_busy    = occ_q;

`ifdef TM_DRAM_STATS_EN
  logic [31:0] stat_reqs_q, stat_reqs_d;
  logic [31:0] stat_wbs_q, stat_wbs_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_reqs_d  = stat_reqs_q + (accept ? 32'd1 : 32'd0);
    stat_wbs_d   = stat_wbs_q + ((accept && req.req_wb) ? 32'd1 : 32'd0);
    stat_stall_d = stat_stall_q + (tick ? 32'($countones(stay_stalled_q)) : 32'd0);
  end

  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      stat_reqs_q  <= '0;
      stat_wbs_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_reqs_q  <= stat_reqs_d;
      stat_wbs_q   <= stat_wbs_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_reqs         = stat_reqs_q;
  assign stat_wbs          = stat_wbs_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_tm_dram_timer.sv
// Bench for tm_dram_timer: directed scenarios plus randomized tokens against an
// integer-arithmetic model of per-thread latency and channel occupancy.
module tb_tm_dram_timer;

  localparam int NT   = 64;
  localparam int TIDW = 6;
  localparam int LATW = 10;
  localparam int LMAX = (1 << LATW) - 1;

  logic            gclk = 1'b0;
  logic            rst;
  logic            tick;
  logic [LATW-1:0] access_time, cycle_time;
  logic [NT-1:0]   stay_stalled;
  logic            busy_drop;
  logic [LATW-1:0] chan_busy;

  tm_dram_timer_if #(.TIDW(TIDW)) req_if ();

  tm_dram_timer #(.NT(NT), .TIDW(TIDW), .LATW(LATW)) dut (
    .gclk         (gclk),
    .rst          (rst),
    .tick         (tick),
    .req          (req_if.slave),
    .access_time  (access_time),
    .cycle_time   (cycle_time),
    .stay_stalled (stay_stalled),
    .busy_drop    (busy_drop),
    .chan_busy    (chan_busy)
  );

  always #5 gclk = ~gclk;

  int  n_tests = 0;
  int  n_fails = 0;
  int  m_rem[NT];
  int  m_occ;
  bit  m_drop;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > LMAX) ? LMAX : v;
  endfunction

  function automatic void model_reset();
    foreach (m_rem[t]) m_rem[t] = 0;
    m_occ  = 0;
    m_drop = 0;
  endfunction

  // Apply one host cycle of the behavioural rules to the model.
  function automatic void model_step(input bit tk, input bit tv, input bit rv,
                                     input int tid, input bit wb,
                                     input int acc_t, input int cyc_t);
    bit waiting;
    waiting = (m_rem[tid] != 0);
    m_drop  = tv && rv && waiting;
    if (tk) begin
      if (m_occ > 0) m_occ--;
      foreach (m_rem[t]) if (m_rem[t] > 0) m_rem[t]--;
    end
    if (tv && rv && !waiting) begin
      m_rem[tid] = sat(m_occ + acc_t + (wb ? cyc_t : 0));
      m_occ      = sat(m_occ + cyc_t * (wb ? 2 : 1));
    end
  endfunction

  function automatic logic [NT-1:0] model_stall();
    logic [NT-1:0] v;
    v = '0;
    foreach (m_rem[t]) v[t] = (m_rem[t] != 0);
    return v;
  endfunction

  task automatic step(input bit tk, input bit tv, input bit rv, input int tid, input bit wb);
    tick                   = tk;
    req_if.req_token_valid = tv;
    req_if.req_valid       = rv;
    req_if.req_tid         = TIDW'(tid);
    req_if.req_wb          = wb;
    @(posedge gclk);
    model_step(tk, tv, rv, tid, wb, int'(access_time), int'(cycle_time));
    #1;
    check_eq("stall", stay_stalled, model_stall());
    check_eq("drop",  busy_drop, m_drop);
    check_eq("occ",   chan_busy, m_occ);
    tick                   = 1'b0;
    req_if.req_token_valid = 1'b0;
    req_if.req_valid       = 1'b0;
    req_if.req_wb          = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_req(input int tid, input bit wb);
    step(1'b0, 1'b1, 1'b1, tid, wb);
  endtask

  initial begin
    rst = 1'b0;
    tick = 1'b0;
    access_time = '0;
    cycle_time  = '0;
    req_if.req_token_valid = 1'b0;
    req_if.req_valid       = 1'b0;
    req_if.req_tid         = '0;
    req_if.req_wb          = 1'b0;
    model_reset();
    #12;
    check_eq("rst_stall", stay_stalled, 64'd0);
    check_eq("rst_drop",  busy_drop, 1'b0);
    check_eq("rst_occ",   chan_busy, 10'd0);
    @(negedge gclk);
    rst = 1'b1;

    // Single miss
    access_time = 10'd5; cycle_time = 10'd2;
    do_req(3, 1'b0);
    check_eq("single_set", stay_stalled[3], 1'b1);
    check_eq("single_occ", chan_busy, 10'd2);
    ticks(2);
    check_eq("single_occ_drain", chan_busy, 10'd0);
    ticks(2);
    check_eq("single_hold4", stay_stalled[3], 1'b1);
    ticks(1);
    check_eq("single_clear5", stay_stalled[3], 1'b0);

    // Contention: back-to-back tid 1 then tid 2
    do_req(1, 1'b0);
    do_req(2, 1'b0);
    check_eq("cont_occ", chan_busy, 10'd4);
    ticks(5);
    check_eq("cont_t1_clear", stay_stalled[1], 1'b0);
    check_eq("cont_t2_hold", stay_stalled[2], 1'b1);
    ticks(2);
    check_eq("cont_t2_clear", stay_stalled[2], 1'b0);

    // Writeback on idle channel
    access_time = 10'd4; cycle_time = 10'd3;
    do_req(9, 1'b1);
    check_eq("wb_occ", chan_busy, 10'd6);
    ticks(6);
    check_eq("wb_hold6", stay_stalled[9], 1'b1);
    ticks(1);
    check_eq("wb_clear7", stay_stalled[9], 1'b0);

    // Duplicate while waiting, and an invalid token that must not drop
    access_time = 10'd5; cycle_time = 10'd2;
    do_req(3, 1'b0);
    do_req(3, 1'b0);
    check_eq("dup_drop", busy_drop, 1'b1);
    check_eq("dup_occ", chan_busy, 10'd2);
    step(1'b0, 1'b1, 1'b0, 3, 1'b0);
    check_eq("dup_drop_once", busy_drop, 1'b0);
    ticks(5);
    check_eq("dup_clear", stay_stalled[3], 1'b0);

    // Zero access time: accepted, no stall, occupancy charged
    access_time = 10'd0; cycle_time = 10'd2;
    ticks(3);
    do_req(20, 1'b0);
    check_eq("zero_nostall", stay_stalled[20], 1'b0);
    check_eq("zero_occ", chan_busy, 10'd2);
    ticks(3);

    // Simultaneous tick and request with occ = 3
    access_time = 10'd5; cycle_time = 10'd3;
    do_req(5, 1'b0);
    check_eq("simul_pre_occ", chan_busy, 10'd3);
    cycle_time = 10'd2;
    step(1'b1, 1'b1, 1'b1, 6, 1'b0);
    check_eq("simul_occ", chan_busy, 10'd4);
    ticks(6);
    check_eq("simul_hold", stay_stalled[6], 1'b1);
    ticks(1);
    check_eq("simul_clear", stay_stalled[6], 1'b0);
    ticks(4);

    // Saturation then asynchronous reset mid-count
    access_time = 10'd1000; cycle_time = 10'd600;
    do_req(10, 1'b0);
    do_req(11, 1'b0);
    do_req(12, 1'b0);
    check_eq("sat_occ", chan_busy, 10'd1023);
    ticks(3);
    check_eq("sat_occ_dec", chan_busy, 10'd1020);
    check_eq("sat_stalls", stay_stalled[12:10], 3'b111);
    #2 rst = 1'b0;
    #1;
    check_eq("async_stall", stay_stalled, 64'd0);
    check_eq("async_occ", chan_busy, 10'd0);
    model_reset();
    @(negedge gclk);
    rst = 1'b1;
    access_time = 10'd5; cycle_time = 10'd2;
    do_req(11, 1'b0);
    check_eq("post_rst_occ", chan_busy, 10'd2);
    check_eq("post_rst_stall", stay_stalled, 64'd1 << 11);
    ticks(6);

    // Randomized traffic, mostly on a few threads to provoke drops
    for (int i = 0; i < 3000; i++) begin
      int tid;
      if (i % 200 == 0) begin
        access_time = LATW'($urandom_range(0, 20));
        cycle_time  = LATW'($urandom_range(0, 8));
      end
      tid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NT - 1))
                                        : int'($urandom_range(0, 7));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, tid, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fails++;
    $display("FAIL timeout: bench did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $fatal(1, "timeout");
  end

endmodule
